// File: rtl/phy_rx_lane_pkg.sv
// Shared PHY definitions for the receive lane: comma symbol and lane FSM encoding.
// The COM value must stay identical to the one the transmit lane inserts.
package phy_rx_lane_pkg;

  localparam logic [7:0] COM = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

endpackage

// File: rtl/phy_rx_lane.sv
// Serial receive lane: deserializes one bit per clk_32f, aligns on COM and
// presents each aligned byte with a data/idle flag once locked.
//
// state  | meaning
// SEARCH | sliding COM search at every bit offset
// ALIGN  | COM found; confirming COM at each following byte boundary
// LOCKED | byte aligned; bytes presented at every boundary until reset
module phy_rx_lane
  import phy_rx_lane_pkg::*;
#(
  parameter logic [7:0]  COM_SYM    = COM,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  rx_state_t  state_q;
  rx_state_t  state_d;
  logic [7:0] sr_q;
  logic [2:0] bit_cnt_q;
  logic [3:0] com_cnt_q;
  logic [7:0] data_q;
  logic       valid_q;

  logic       boundary;
  logic       sr_is_com;
  logic [3:0] com_next;
  logic       lock_hit;

  assign boundary  = (bit_cnt_q == 3'd0);
  assign sr_is_com = (sr_q == COM_SYM);
  assign com_next  = com_cnt_q + 4'd1;
  assign lock_hit  = (com_next == LOCK_CNT);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH: begin
        if (sr_is_com) state_d = ALIGN;
      end
      ALIGN: begin
        if (boundary) begin
          if (!sr_is_com)    state_d = SEARCH;
          else if (lock_hit) state_d = LOCKED;
        end
      end
      LOCKED:  state_d = LOCKED;
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    active = (state_q == LOCKED);
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sr_q <= 8'h00;
    end else begin
      sr_q <= {sr_q[6:0], data_in};
    end
  end

  // A broken alignment zeroes the counters; the sliding search restarts next cycle.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd0;
    end else begin
      case (state_q)
        SEARCH: begin
          bit_cnt_q <= sr_is_com ? 3'd1 : 3'd0;
          com_cnt_q <= sr_is_com ? 4'd1 : 4'd0;
        end
        ALIGN: begin
          if (boundary && !sr_is_com) begin
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (boundary) com_cnt_q <= lock_hit ? 4'd0 : com_next;
          end
        end
        LOCKED: begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          com_cnt_q <= 4'd0;
        end
        default: begin
          bit_cnt_q <= 3'd0;
          com_cnt_q <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else if (state_q == LOCKED && boundary) begin
      data_q  <= sr_q;
      valid_q <= !sr_is_com;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_phy_rx_lane.sv
// Randomized self-checking bench for phy_rx_lane against a bit-position model
// of COM acquisition and byte presentation.
module tb_phy_rx_lane;
  import phy_rx_lane_pkg::*;

  localparam int LOCK_COUNT = 4;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_32f = ~clk_32f;

  phy_rx_lane #(.LOCK_COUNT(LOCK_COUNT)) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Model: positions are edge numbers since reset release. A COM seen during
  // search anchors a candidate; COMs must recur every 8 edges from the anchor.
  logic [7:0] last8;
  int         m_edge;
  int         m_anchor;
  int         m_lock_edge;
  bit         m_locked;
  logic [7:0] m_data;
  bit         m_valid;

  function automatic void model_reset();
    last8       = 8'h00;
    m_edge      = 0;
    m_anchor    = -1;
    m_lock_edge = -1;
    m_locked    = 1'b0;
    m_data      = 8'h00;
    m_valid     = 1'b0;
  endfunction

  function automatic void model_edge(input bit b);
    m_edge++;
    if (m_locked) begin
      if ((m_edge - m_lock_edge) % 8 == 0) begin
        m_data  = last8;
        m_valid = (last8 != COM);
      end
    end else if (m_anchor >= 0) begin
      if ((m_edge - m_anchor) % 8 == 0) begin
        if (last8 != COM) m_anchor = -1;
        else if ((m_edge - m_anchor) / 8 + 1 == LOCK_COUNT) begin
          m_locked    = 1'b1;
          m_lock_edge = m_edge;
        end
      end
    end else if (last8 == COM) begin
      m_anchor = m_edge;
    end
    last8 = {last8[6:0], b};
  endfunction

  task automatic step(input bit b);
    data_in = b;
    model_edge(b);
    @(posedge clk_32f);
    #1;
    check("active", active, m_locked);
    check("valid_out", valid_out, m_valid);
    check("data_out", data_out, m_data);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(v[i]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_async_active", active, 0);
    check("rst_async_valid", valid_out, 0);
    check("rst_async_data", data_out, 0);
    repeat (3) begin
      data_in = 1'($urandom);
      @(posedge clk_32f);
      #1;
      check("rst_hold_active", active, 0);
      check("rst_hold_valid", valid_out, 0);
      check("rst_hold_data", data_out, 0);
    end
    @(negedge clk_32f);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic lock_and_check_edge(input string tag);
    for (int i = 0; i < LOCK_COUNT; i++) send_byte(COM);
    check({tag, "_not_yet"}, active, 0);
    step(1'($urandom));
    check({tag, "_lock_edge"}, active, 1);
    for (int i = 0; i < 7; i++) step(1'($urandom));
  endtask

  initial begin
    model_reset();

    // Reset and lock at an arbitrary bit offset.
    do_reset();
    step(1'b1); step(1'b0); step(1'b1);
    for (int i = 0; i < LOCK_COUNT; i++) send_byte(COM);
    check("s2_not_yet", active, 0);
    check("s2_valid_low", valid_out, 0);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] d12;
      d12 = 8'h12;
      step(d12[i]);
      if (i == 7) check("s2_lock_edge", active, 1);
    end
    send_byte(8'h34);
    check("s3_data12", data_out, 8'h12);
    check("s3_valid12", valid_out, 1);
    send_byte(8'hA5);
    check("s3_data34", data_out, 8'h34);
    check("s3_valid34", valid_out, 1);

    // Idle COM between data bytes while locked.
    send_byte(COM);
    check("s4_valid_a5", valid_out, 1);
    send_byte(8'hA5);
    check("s4_data_com", data_out, COM);
    check("s4_valid_com", valid_out, 0);
    send_byte(8'h5A);
    check("s4_data_a5", data_out, 8'hA5);
    check("s4_valid_a5b", valid_out, 1);
    check("s4_active", active, 1);

    // Alignment broken by a non-COM byte, then a clean lock.
    do_reset();
    send_byte(COM);
    send_byte(COM);
    send_byte(8'h00);
    check("s5_no_lock", active, 0);
    lock_and_check_edge("s5");

    // Reset halfway through a data byte, then relock.
    send_byte(8'h77);
    for (int i = 0; i < 4; i++) step(1'($urandom));
    check("s6_pre_data", data_out, 8'h77);
    do_reset();
    lock_and_check_edge("s6");

    // Randomized sessions: junk, lock attempts, mixed traffic, occasional mid-byte reset.
    for (int s = 0; s < 24; s++) begin
      do_reset();
      for (int i = 0; i < int'($urandom_range(0, 20)); i++) step(1'($urandom));
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
        if ($urandom_range(0, 7) == 0) send_byte(8'($urandom));
        else send_byte(COM);
      end
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 3) == 0) send_byte(COM);
        else send_byte(8'($urandom));
      end
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 7)); i++) step(1'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/phy_rx_lane.md
Name: phy_rx_lane

Overview:
Single-lane serial receiver for the PCIe-style PHY, the counterpart of PHY_TX's serial lane outputs (data_out_0/data_out_1). It runs on clk_32f, deserializes one bit per clock, and acquires byte alignment on the COM symbol (8'hBC). Once locked, it presents each received byte, and a valid flag that is low for idle COM bytes, to downstream lane de-striping logic. PHY_RX instantiates one phy_rx_lane per lane.

Parameters:
COM, 8'hBC, comma/idle symbol used for alignment; idle filler on the lane.
LOCK_COUNT, 4, number of consecutive byte-aligned COMs required to lock (legal range 2..15).

Ports:
clk_32f  input  1  bit clock; one serial bit per rising edge.
reset  input  1  asynchronous, active-low reset.
data_in  input  1  serial lane bit, MSB of each byte first.
data_out  output  8  last received aligned byte; held for 8 cycles.
valid_out  output  1  data_out is a data byte (not COM) while locked; held with data_out.
active  output  1  lane locked.

Behaviour:
- Reset (reset==0, async): state=SEARCH; sr, bit_cnt, com_cnt, data_out=8'h00; valid_out=0; active=0. All outputs update asynchronously on reset assertion; normal operation starts on the first clk_32f edge after release.
- Shift register: every edge sr <= {sr[6:0], data_in}, in all states.
- bit_cnt (3 bits) counts bits since the last byte boundary and wraps 7->0. The boundary is the cycle in which bit_cnt==0, when sr holds a complete aligned byte.
- SEARCH: sr is compared with COM in every cycle (any bit offset). On a match: ALIGN, bit_cnt<=1, com_cnt<=1. Otherwise stay in SEARCH.
- ALIGN: bit_cnt increments each cycle. At a boundary:
  - If sr==COM and com_cnt+1==LOCK_COUNT: go to LOCKED, active<=1, com_cnt<=0.
  - If sr==COM otherwise: com_cnt<=com_cnt+1.
  - If sr!=COM: go to SEARCH, com_cnt<=0. The byte that broke alignment is not rechecked for a COM at another offset in that same cycle; the search resumes on the next cycle.
- Lock timing: active rises on the edge one cycle after the last bit of the LOCK_COUNT-th COM is shifted in.
- LOCKED: bit_cnt increments each cycle. At every boundary, data_out<=sr and valid_out<=(sr!=COM). Both are held until the next boundary, so the latency is 1 clk_32f cycle from the byte's last bit to data_out. The first byte is presented at the first boundary after lock.
- LOCKED persists until reset; there is no in-band loss-of-lock detection in this revision.
- While not LOCKED: valid_out=0, active=0, data_out holds 8'h00.
- Reset asserted mid-byte or mid-lock aborts immediately. The partial byte is discarded and reacquisition restarts in SEARCH.

Decomposition:
- Shared PHY package/include: COM value (8'hBC), shared with PHY_TX; state encodings SEARCH=2'd0, ALIGN=2'd1, LOCKED=2'd2.
- No sub-module required. The shift register, counters and FSM stay in one module.
- PHY_RX wraps two phy_rx_lane instances plus lane de-striping.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with random data_in -> data_out=8'h00, valid_out=0, active=0 throughout, and immediately on the asserting edge.
2. Lock at arbitrary offset: after reset release, 3 junk bits (101), then 4×8'hBC MSB-first -> active=1 exactly 1 cycle after the 32nd COM bit; valid_out remains 0.
3. Data after lock: send 8'h12 then 8'h34 -> data_out=8'h12, valid_out=1 for 8 cycles starting 1 cycle after its last bit, then data_out=8'h34, valid_out=1.
4. Idle while locked: send 8'hBC between 8'hA5 bytes -> valid_out=1 (A5), valid_out=0 for 8 cycles (BC), then valid_out=1 (A5); active stays 1.
5. Failed alignment: 2×COM, 8'h00, then 4×COM -> active stays 0 through the 8'h00 byte (FSM back in SEARCH), then rises 1 cycle after the last of the 4 following COMs.
6. Reset mid-lock: assert reset=0 halfway through a data byte -> active, valid_out and data_out clear asynchronously; after release, 4 COMs relock per scenario 2 timing.
